// File: rtl/alu_core_reg.sv
// Registered 32-bit execute-stage ALU: shifts, mul, div, add/sub with flags,
// logic ops and set-less-than, one cycle of latency behind a valid strobe.
module alu_core_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] sr,
  input  logic [31:0] tg,
  input  logic [3:0]  alu_op,
  output logic        out_valid,
  output logic [31:0] result1,
  output logic [31:0] result2,
  output logic        of,
  output logic        cf,
  output logic        equal
);

  localparam int unsigned DW = 32;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  logic          out_valid_q;
  logic [DW-1:0] result1_q, result1_d;
  logic [DW-1:0] result2_q, result2_d;
  logic          of_q, of_d;
  logic          cf_q, cf_d;
  logic          equal_q, equal_d;

  logic [DW-1:0]   r1_c, r2_c;
  logic            of_c, cf_c;
  logic [4:0]      shamt_c;
  logic [2*DW-1:0] prod_c;
  logic [DW:0]     sum_c, diff_c;

  assign shamt_c = tg[4:0];
  assign prod_c  = (2*DW)'(sr) * (2*DW)'(tg);
  assign sum_c   = (DW+1)'(sr) + (DW+1)'(tg);
  assign diff_c  = (DW+1)'(sr) - (DW+1)'(tg);

  // Operation select; fields not produced by an opcode stay zero.
  always_comb begin
    r1_c = '0;
    r2_c = '0;
    of_c = 1'b0;
    cf_c = 1'b0;
    case (alu_op)
      OP_SLL:  r1_c = sr << shamt_c;
      OP_SRA:  r1_c = DW'($signed(sr) >>> shamt_c);
      OP_SRL:  r1_c = sr >> shamt_c;
      OP_MUL: begin
        r1_c = prod_c[DW-1:0];
        r2_c = prod_c[2*DW-1:DW];
      end
      OP_DIV: begin
        // Divide by zero returns all-ones quotient and the dividend as remainder.
        if (tg == '0) begin
          r1_c = '1;
          r2_c = sr;
        end else begin
          r1_c = sr / tg;
          r2_c = sr % tg;
        end
      end
      OP_ADD: begin
        r1_c = sum_c[DW-1:0];
        cf_c = sum_c[DW];
        of_c = (sr[DW-1] == tg[DW-1]) && (sum_c[DW-1] != sr[DW-1]);
      end
      OP_SUB: begin
        r1_c = diff_c[DW-1:0];
        cf_c = diff_c[DW];
        of_c = (sr[DW-1] != tg[DW-1]) && (diff_c[DW-1] != sr[DW-1]);
      end
      OP_AND:  r1_c = sr & tg;
      OP_OR:   r1_c = sr | tg;
      OP_XOR:  r1_c = sr ^ tg;
      OP_NOR:  r1_c = ~(sr | tg);
      OP_SLT:  r1_c = DW'($signed(sr) < $signed(tg));
      OP_SLTU: r1_c = DW'(sr < tg);
      default: r1_c = '0;
    endcase
  end

  // Load on valid, otherwise hold.
  always_comb begin
    result1_d = result1_q;
    result2_d = result2_q;
    of_d      = of_q;
    cf_d      = cf_q;
    equal_d   = equal_q;
    if (in_valid) begin
      result1_d = r1_c;
      result2_d = r2_c;
      of_d      = of_c;
      cf_d      = cf_c;
      equal_d   = (sr == tg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result1_q   <= '0;
      result2_q   <= '0;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      equal_q     <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      result1_q   <= result1_d;
      result2_q   <= result2_d;
      of_q        <= of_d;
      cf_q        <= cf_d;
      equal_q     <= equal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result1   = result1_q;
  assign result2   = result2_q;
  assign of        = of_q;
  assign cf        = cf_q;
  assign equal     = equal_q;

endmodule

// File: tb/tb_alu_core_reg.sv
// Self-checking bench for alu_core_reg: directed plan vectors, randomized ops
// against an arithmetic reference model, idle hold and async reset.
module tb_alu_core_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] sr;
  logic [31:0] tg;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic [31:0] result1;
  logic [31:0] result2;
  logic        of;
  logic        cf;
  logic        equal;

  int checks = 0;
  int errors = 0;

  logic        exp_valid;
  logic [31:0] exp_r1, exp_r2;
  logic        exp_of, exp_cf, exp_eq;

  alu_core_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sr        (sr),
    .tg        (tg),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .result1   (result1),
    .result2   (result2),
    .of        (of),
    .cf        (cf),
    .equal     (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".result1"},   result1,        exp_r1);
    chk({tag, ".result2"},   result2,        exp_r2);
    chk({tag, ".of"},        32'(of),        32'(exp_of));
    chk({tag, ".cf"},        32'(cf),        32'(exp_cf));
    chk({tag, ".equal"},     32'(equal),     32'(exp_eq));
  endtask

  // Reference model written from the arithmetic definition of each operation.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r1, output logic [31:0] r2,
                       output logic o, output logic c);
    longint unsigned ua, ub, full, pow2;
    longint sa, sb, s;
    int amt;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    amt  = int'(b % 32);
    pow2 = 64'd1 << amt;
    r1 = 32'd0; r2 = 32'd0; o = 1'b0; c = 1'b0;
    case (int'(op))
      0: begin full = ua * pow2; r1 = full[31:0]; end
      1: begin
        if (a[31]) begin full = (~ua & 64'hFFFF_FFFF) / pow2; r1 = ~full[31:0]; end
        else begin full = ua / pow2; r1 = full[31:0]; end
      end
      2: begin full = ua / pow2; r1 = full[31:0]; end
      3: begin full = ua * ub; r1 = full[31:0]; r2 = full[63:32]; end
      4: begin
        if (b == 32'd0) begin r1 = 32'hFFFF_FFFF; r2 = a; end
        else begin full = ua / ub; r1 = full[31:0]; full = ua % ub; r2 = full[31:0]; end
      end
      5: begin
        full = ua + ub; r1 = full[31:0]; c = (full >= 64'h1_0000_0000);
        s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6: begin
        full = ua - ub; r1 = full[31:0]; c = (ua < ub);
        s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      7:  r1 = a & b;
      8:  r1 = a | b;
      9:  r1 = a ^ b;
      10: r1 = ~(a | b);
      11: r1 = (sa < sb) ? 32'd1 : 32'd0;
      12: r1 = (ua < ub) ? 32'd1 : 32'd0;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = op;
    sr       = a;
    tg       = b;
    model(op, a, b, exp_r1, exp_r2, exp_of, exp_cf);
    exp_eq    = (a == b);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  logic [3:0]  d_op [20];
  logic [31:0] d_a  [20];
  logic [31:0] d_b  [20];

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    d_op[0]  = 4'd0;  d_a[0]  = 32'h0000_0001; d_b[0]  = 32'd4;
    d_op[1]  = 4'd1;  d_a[1]  = 32'hF000_0000; d_b[1]  = 32'd4;
    d_op[2]  = 4'd2;  d_a[2]  = 32'hF000_0000; d_b[2]  = 32'd4;
    d_op[3]  = 4'd3;  d_a[3]  = 32'h10;        d_b[3]  = 32'h4;
    d_op[4]  = 4'd3;  d_a[4]  = 32'hFFFF_FFFF; d_b[4]  = 32'd2;
    d_op[5]  = 4'd4;  d_a[5]  = 32'h10;        d_b[5]  = 32'd3;
    d_op[6]  = 4'd4;  d_a[6]  = 32'hDEAD_BEEF; d_b[6]  = 32'd0;
    d_op[7]  = 4'd5;  d_a[7]  = 32'h7FFF_FFFF; d_b[7]  = 32'd1;
    d_op[8]  = 4'd5;  d_a[8]  = 32'hFFFF_FFFF; d_b[8]  = 32'd1;
    d_op[9]  = 4'd6;  d_a[9]  = 32'h8000_0000; d_b[9]  = 32'd1;
    d_op[10] = 4'd7;  d_a[10] = 32'hFF00_FF00; d_b[10] = 32'h0F0F_0F0F;
    d_op[11] = 4'd8;  d_a[11] = 32'hF000_0000; d_b[11] = 32'h0000_FFFF;
    d_op[12] = 4'd9;  d_a[12] = 32'hAAAA_5555; d_b[12] = 32'hFFFF_0000;
    d_op[13] = 4'd10; d_a[13] = 32'h0;         d_b[13] = 32'h0;
    d_op[14] = 4'd11; d_a[14] = 32'hFFFF_FFFB; d_b[14] = 32'd3;
    d_op[15] = 4'd11; d_a[15] = 32'd5;         d_b[15] = 32'hFFFF_FFFD;
    d_op[16] = 4'd12; d_a[16] = 32'd1;         d_b[16] = 32'hFFFF_FFFF;
    d_op[17] = 4'd12; d_a[17] = 32'hFFFF_FFFF; d_b[17] = 32'd1;
    d_op[18] = 4'd5;  d_a[18] = 32'h1234;      d_b[18] = 32'h1234;
    d_op[19] = 4'd13; d_a[19] = 32'h7FFF_FFFF; d_b[19] = 32'd1;

    rst = 1'b1; in_valid = 1'b0; sr = '0; tg = '0; alu_op = '0;
    exp_valid = 1'b0; exp_r1 = '0; exp_r2 = '0; exp_of = 1'b0; exp_cf = 1'b0; exp_eq = 1'b0;
    #12;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Spot checks of hand-derived plan values, independent of the model.
    do_op(4'd0, 32'h1, 32'd4, "sll");
    chk("sll.const", result1, 32'h0000_0010);
    do_op(4'd4, 32'h10, 32'd3, "div");
    chk("div.q.const", result1, 32'd5);
    chk("div.r.const", result2, 32'd1);
    do_op(4'd6, 32'h8000_0000, 32'd1, "sub");
    chk("sub.const", result1, 32'h7FFF_FFFF);
    chk("sub.of.const", 32'(of), 32'd1);

    for (int i = 0; i < 20; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], $sformatf("dir%0d.op%0d", i, d_op[i]));
    end

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      do_op(rop, ra, rb, $sformatf("rnd%0d.op%0d", i, rop));
    end

    // Idle: registers hold while out_valid drops.
    do_op(4'd3, 32'hFFFF_FFFF, 32'd2, "pre_idle");
    @(negedge clk);
    in_valid = 1'b0;
    sr = 32'h5555_AAAA; tg = 32'h5555_AAAA; alu_op = 4'd9;
    exp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("idle%0d", i));
    end

    // Asynchronous reset mid-stream, observed before any clock edge.
    do_op(4'd3, 32'hFFFF_FFFF, 32'd2, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1; sr = 32'h1234; tg = 32'h1234; alu_op = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    exp_valid = 1'b0; exp_r1 = '0; exp_r2 = '0; exp_of = 1'b0; exp_cf = 1'b0; exp_eq = 1'b0;
    chk_all("async_rst");
    @(posedge clk);
    #1;
    chk_all("rst_held");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst_idle");
    do_op(4'd5, 32'hFFFF_FFFF, 32'd1, "post_rst_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core_reg.md
Name: alu_core_reg

Overview:
32-bit registered ALU for the MIPS datapath (execute stage). Takes two operands and a 4-bit opcode and computes one of 13 operations: shifts, multiply, divide, add/subtract with flags, logic, and signed/unsigned set-less-than. All outputs are registered with one-cycle latency behind a simple valid strobe.

Parameters:
None. The data width is fixed at 32 bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and opcode are valid this cycle
sr  input  32  source operand A (shift: value to shift)
tg  input  32  source operand B (shift: amount in tg[4:0])
alu_op  input  4  operation select
out_valid  output  1  registered copy of in_valid
result1  output  32  primary result
result2  output  32  secondary result (mul high word / div remainder)
of  output  1  signed overflow (add/sub only)
cf  output  1  carry (add) / borrow (sub)
equal  output  1  sr == tg, for any opcode

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst). While rst=1, all outputs are 0.
- Latency: 1 cycle. On each rising clk edge with in_valid=1, the registers load the combinational results of sr/tg/alu_op.
- Hold on idle: with in_valid=0, result1, result2, of, cf and equal hold their values; out_valid <= in_valid every cycle.
- Opcode 0, sll: result1 = sr << tg[4:0].
- Opcode 1, sra: arithmetic right shift of sr by tg[4:0].
- Opcode 2, srl: logical right shift of sr by tg[4:0].
- Opcode 3, mul: unsigned 32x32 -> 64-bit product; result1 = product[31:0], result2 = product[63:32].
- Opcode 4, div: unsigned; result1 = sr / tg, result2 = sr % tg. If tg=0: result1 = 0xFFFFFFFF, result2 = sr.
- Opcode 5, add: result1 = sr + tg (mod 2^32).
  - cf = carry out of bit 31.
  - of = 1 when both operands have the same sign and the result sign differs.
- Opcode 6, sub: result1 = sr - tg.
  - cf = borrow, i.e. sr < tg unsigned.
  - of = 1 when the operand signs differ and the result sign differs from sr.
- Opcodes 7-10, logic: 7 and, 8 or, 9 xor, 10 nor (bitwise).
- Opcode 11, slt: result1 = {31'b0, signed(sr) < signed(tg)}.
- Opcode 12, sltu: result1 = {31'b0, sr < tg unsigned}.
- Opcodes 13-15 (reserved): result1 = 0, result2 = 0, of = 0, cf = 0.
- Zeroed fields:
  - result2 = 0 for every opcode except 3 and 4.
  - of = cf = 0 for every opcode except 5 and 6.
- equal: registered flag, equal = (sr == tg), valid for every opcode.
- Reset mid-operation: a pending result is discarded; outputs go to 0 immediately and stay 0 until the first valid input after rst deasserts.
- Back-to-back: a new operation may be accepted every cycle. A divide also completes in 1 cycle, using a combinational divider.

Test Plan:
- Shifts, expected result1 one cycle later:
  - op0: sr=0x00000001, tg=4 -> 0x00000010.
  - op1: sr=0xF0000000, tg=4 -> 0xFF000000.
  - op2: sr=0xF0000000, tg=4 -> 0x0F000000.
- Mul/div:
  - op3: sr=0x10, tg=0x4 -> result1=0x40, result2=0.
  - op3: sr=0xFFFFFFFF, tg=2 -> result1=0xFFFFFFFE, result2=0x1.
  - op4: sr=0x10, tg=3 -> result1=5, result2=1.
  - op4: tg=0 -> result1=0xFFFFFFFF, result2=sr.
- Add/sub flags:
  - op5: 0x7FFFFFFF + 1 -> 0x80000000, of=1, cf=0.
  - op5: 0xFFFFFFFF + 1 -> 0, of=0, cf=1.
  - op6: 0x80000000 - 1 -> 0x7FFFFFFF, of=1, cf=0.
- Logic:
  - op7: 0xFF00FF00 & 0x0F0F0F0F -> 0x0F000F00.
  - op8: 0xF0000000 | 0x0000FFFF -> 0xF000FFFF.
  - op9: 0xAAAA5555 ^ 0xFFFF0000 -> 0x55555555.
  - op10: 0 nor 0 -> 0xFFFFFFFF.
- Compares:
  - op11: (-5, 3) -> 1; (5, -3) -> 0.
  - op12: (1, 0xFFFFFFFF) -> 1; (0xFFFFFFFF, 1) -> 0.
  - Any op with sr = tg = 0x1234 -> equal=1.
- Reset/valid:
  - Assert rst mid-stream -> all outputs 0 without waiting for a clk edge.
  - in_valid=0 for 3 cycles -> outputs hold, out_valid=0.
  - op13 -> result1 = result2 = of = cf = 0.
